// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC, issues instruction-memory requests over a
// req/ready handshake, applies decode stalls and execute redirects.
module fetch_sequencer #(
    parameter int                   PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(32'hBFC00000)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                stall_i,
    input  logic                redirect_valid_i,
    input  logic [PC_WIDTH-1:0] redirect_target_i,
    output logic                imem_req_o,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic                imem_ready_i,
    input  logic [31:0]         imem_rdata_i,
    output logic                fetch_valid_o,
    output logic [31:0]         fetch_instr_o,
    output logic [PC_WIDTH-1:0] fetch_pc_o,
    output logic                misalign_err_o
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN,
        ERR
    } state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic                pend_err_q, pend_err_d;
    logic [31:0]         hold_instr_q, hold_instr_d;
    logic [PC_WIDTH-1:0] hold_pc_q, hold_pc_d;
    logic                misalign_err_q, misalign_err_d;

    logic                target_bad;
    logic                redir_bad;
    logic [PC_WIDTH-1:0] pc_inc;

    assign target_bad     = (redirect_target_i[1:0] != 2'b00);
    assign redir_bad      = redirect_valid_i && target_bad;
    assign pc_inc         = pc_q + PC_WIDTH'(4);
    assign imem_addr_o    = pc_q;
    assign misalign_err_o = misalign_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            pc_q           <= RESET_VECTOR;
            pend_pc_q      <= '0;
            pend_err_q     <= 1'b0;
            hold_instr_q   <= '0;
            hold_pc_q      <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            pend_pc_q      <= pend_pc_d;
            pend_err_q     <= pend_err_d;
            hold_instr_q   <= hold_instr_d;
            hold_pc_q      <= hold_pc_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        pend_pc_d      = pend_pc_q;
        pend_err_d     = pend_err_q;
        hold_instr_d   = hold_instr_q;
        hold_pc_d      = hold_pc_q;
        misalign_err_d = misalign_err_q;
        imem_req_o     = 1'b0;
        fetch_valid_o  = 1'b0;
        fetch_instr_o  = '0;
        fetch_pc_o     = '0;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end

            REQ: begin
                imem_req_o = 1'b1;
                if (redir_bad) begin
                    state_d        = ERR;
                    misalign_err_d = 1'b1;
                end else if (redirect_valid_i) begin
                    if (imem_ready_i) begin
                        pc_d = redirect_target_i;
                    end else begin
                        pend_pc_d  = redirect_target_i;
                        pend_err_d = 1'b0;
                        state_d    = DRAIN;
                    end
                end else if (imem_ready_i) begin
                    // Presented even under stall; decode only takes it once stall drops.
                    fetch_valid_o = 1'b1;
                    fetch_instr_o = imem_rdata_i;
                    fetch_pc_o    = pc_q;
                    pc_d          = pc_inc;
                    if (stall_i) begin
                        hold_instr_d = imem_rdata_i;
                        hold_pc_d    = pc_q;
                        state_d      = HOLD;
                    end
                end
            end

            HOLD: begin
                if (redir_bad) begin
                    state_d        = ERR;
                    misalign_err_d = 1'b1;
                end else if (redirect_valid_i) begin
                    pc_d    = redirect_target_i;
                    state_d = REQ;
                end else begin
                    fetch_valid_o = 1'b1;
                    fetch_instr_o = hold_instr_q;
                    fetch_pc_o    = hold_pc_q;
                    if (!stall_i) begin
                        state_d = REQ;
                    end
                end
            end

            DRAIN: begin
                // The wrong-path access must complete before the new target is requested.
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    if (redir_bad || (!redirect_valid_i && pend_err_q)) begin
                        state_d        = ERR;
                        misalign_err_d = 1'b1;
                    end else begin
                        pc_d    = redirect_valid_i ? redirect_target_i : pend_pc_q;
                        state_d = REQ;
                    end
                end else if (redirect_valid_i) begin
                    pend_pc_d  = redirect_target_i;
                    pend_err_d = target_bad;
                end
            end

            ERR: begin
                state_d = ERR;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_fetch_sequencer;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_target_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        fetch_valid_o;
    logic [31:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic        misalign_err_o;

    int nCompared = 0;
    int nMismatched = 0;
    int cycleNo = 0;

    // Model of the fetch unit's architectural situation.
    bit          mDead, mErr, mStartup, mDraining, mDrainBad, mHeld;
    logic [31:0] mPc, mDrainTarget, mHeldInstr, mHeldPc;

    fetch_sequencer #(.PC_WIDTH(32), .RESET_VECTOR(RV)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_target_i(redirect_target_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_ready_i     (imem_ready_i),
        .imem_rdata_i     (imem_rdata_i),
        .fetch_valid_o    (fetch_valid_o),
        .fetch_instr_o    (fetch_instr_o),
        .fetch_pc_o       (fetch_pc_o),
        .misalign_err_o   (misalign_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void modelReset();
        mDead = 0; mErr = 0; mStartup = 1; mDraining = 0; mDrainBad = 0; mHeld = 0;
        mPc = RV; mDrainTarget = '0; mHeldInstr = '0; mHeldPc = '0;
    endfunction

    function automatic bit modelReq();
        return !mDead && !mStartup && !mHeld;
    endfunction

    function automatic void modelDie();
        mDead = 1; mErr = 1; mHeld = 0; mDraining = 0;
    endfunction

    task automatic compareWord(input string name, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycleNo, got, exp);
        end
    endtask

    task automatic compareBit(input string name, input logic got, input logic exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cycleNo, got, exp);
        end
    endtask

    task automatic checkOutput();
        logic        expReq, expValid, expErr;
        logic [31:0] expAddr, expInstr, expPc;
        expValid = 0; expInstr = '0; expPc = '0;
        if (!rst_ni) begin
            expReq = 0; expAddr = RV; expErr = 0;
        end else begin
            expReq = modelReq(); expAddr = mPc; expErr = mErr;
            if (redirect_valid_i) begin
                expValid = 0;
            end else if (mHeld) begin
                expValid = 1; expInstr = mHeldInstr; expPc = mHeldPc;
            end else if (expReq && !mDraining && imem_ready_i) begin
                expValid = 1; expInstr = imem_rdata_i; expPc = mPc;
            end
        end
        compareBit("imem_req", imem_req_o, expReq);
        compareWord("imem_addr", imem_addr_o, expAddr);
        compareBit("fetch_valid", fetch_valid_o, expValid);
        compareWord("fetch_instr", fetch_instr_o, expInstr);
        compareWord("fetch_pc", fetch_pc_o, expPc);
        compareBit("misalign_err", misalign_err_o, expErr);
    endtask

    // Advances the model by one clock edge using the inputs applied this cycle.
    function automatic void modelStep();
        bit          bad, b;
        logic [31:0] t;
        bad = (redirect_target_i[1:0] != 2'b00);
        if (!rst_ni) begin
            modelReset();
        end else if (mDead) begin
        end else if (mStartup) begin
            mStartup = 0;
        end else if (mHeld) begin
            if (redirect_valid_i) begin
                if (bad) modelDie();
                else begin mPc = redirect_target_i; mHeld = 0; end
            end else if (!stall_i) begin
                mHeld = 0;
            end
        end else if (mDraining) begin
            if (imem_ready_i) begin
                t = redirect_valid_i ? redirect_target_i : mDrainTarget;
                b = redirect_valid_i ? bad : mDrainBad;
                mDraining = 0;
                if (b) modelDie();
                else mPc = t;
            end else if (redirect_valid_i) begin
                mDrainTarget = redirect_target_i;
                mDrainBad = bad;
            end
        end else begin
            if (redirect_valid_i) begin
                if (bad) modelDie();
                else if (imem_ready_i) mPc = redirect_target_i;
                else begin mDraining = 1; mDrainTarget = redirect_target_i; mDrainBad = 0; end
            end else if (imem_ready_i) begin
                if (stall_i) begin mHeld = 1; mHeldInstr = imem_rdata_i; mHeldPc = mPc; end
                mPc = mPc + 32'd4;
            end
        end
    endfunction

    task automatic applyStimulus(input bit rst, input bit stall, input bit rv,
                                 input logic [31:0] rt, input bit ready, input logic [31:0] rdata);
        @(negedge clk_i);
        rst_ni = rst; stall_i = stall; redirect_valid_i = rv;
        redirect_target_i = rt; imem_ready_i = ready; imem_rdata_i = rdata;
        #1;
        cycleNo++;
        checkOutput();
        modelStep();
    endtask

    initial begin
        int pct;
        int deadCount;
        bit rst, stall, rv, ready;
        logic [31:0] rt, rnd;
        modelReset();

        // Reset state
        applyStimulus(0, 0, 0, '0, 0, '0);
        compareBit("rst_req", imem_req_o, 1'b0);
        compareWord("rst_addr", imem_addr_o, 32'hBFC00000);
        compareBit("rst_valid", fetch_valid_o, 1'b0);
        compareBit("rst_err", misalign_err_o, 1'b0);
        applyStimulus(0, 0, 0, '0, 0, '0);

        // Zero-wait fetch, then a 3-cycle stall as BFC00004 returns
        applyStimulus(1, 0, 0, '0, 0, '0);
        compareBit("idle_req", imem_req_o, 1'b0);
        applyStimulus(1, 0, 0, '0, 1, 32'h00000013);
        compareWord("first_addr", imem_addr_o, 32'hBFC00000);
        compareBit("first_valid", fetch_valid_o, 1'b1);
        compareWord("first_pc", fetch_pc_o, 32'hBFC00000);
        applyStimulus(1, 1, 0, '0, 1, 32'h00100093);
        compareWord("second_addr", imem_addr_o, 32'hBFC00004);
        compareWord("second_pc", fetch_pc_o, 32'hBFC00004);
        applyStimulus(1, 1, 0, '0, 0, '0);
        compareBit("hold_req", imem_req_o, 1'b0);
        compareWord("hold_instr", fetch_instr_o, 32'h00100093);
        applyStimulus(1, 1, 0, '0, 0, '0);
        compareWord("hold_pc", fetch_pc_o, 32'hBFC00004);
        applyStimulus(1, 0, 0, '0, 0, '0);
        compareBit("release_valid", fetch_valid_o, 1'b1);
        compareBit("release_req", imem_req_o, 1'b0);

        // Redirect to 0x100 during a slow access at BFC00008
        applyStimulus(1, 0, 1, 32'h100, 0, '0);
        compareWord("after_stall_addr", imem_addr_o, 32'hBFC00008);
        compareBit("redir_valid", fetch_valid_o, 1'b0);
        applyStimulus(1, 0, 0, '0, 0, '0);
        applyStimulus(1, 0, 0, '0, 0, '0);
        compareWord("drain_addr", imem_addr_o, 32'hBFC00008);
        applyStimulus(1, 0, 0, '0, 1, 32'hDEADBEEF);
        compareBit("drain_discard", fetch_valid_o, 1'b0);

        // Redirect to 0x200 together with stall while holding
        applyStimulus(1, 1, 0, '0, 1, 32'h00300193);
        compareWord("target_addr", imem_addr_o, 32'h00000100);
        applyStimulus(1, 1, 1, 32'h200, 0, '0);
        compareBit("hold_redir_valid", fetch_valid_o, 1'b0);
        applyStimulus(1, 0, 0, '0, 1, 32'h00400213);
        compareWord("hold_redir_addr", imem_addr_o, 32'h00000200);
        compareWord("hold_redir_instr", fetch_instr_o, 32'h00400213);

        // PC wrap
        applyStimulus(1, 0, 1, 32'hFFFFFFFC, 1, 32'h11111111);
        applyStimulus(1, 0, 0, '0, 1, 32'h22222222);
        compareWord("wrap_pre_addr", imem_addr_o, 32'hFFFFFFFC);
        applyStimulus(1, 0, 0, '0, 0, '0);
        compareWord("wrap_addr", imem_addr_o, 32'h00000000);

        // Misaligned redirect is sticky until reset
        applyStimulus(1, 0, 1, 32'h102, 0, '0);
        applyStimulus(1, 0, 0, '0, 0, '0);
        compareBit("err_set", misalign_err_o, 1'b1);
        compareBit("err_req", imem_req_o, 1'b0);
        applyStimulus(1, 0, 1, 32'h300, 0, '0);
        compareBit("err_sticky", misalign_err_o, 1'b1);
        applyStimulus(0, 0, 0, '0, 0, '0);
        compareBit("err_cleared", misalign_err_o, 1'b0);
        applyStimulus(1, 0, 0, '0, 0, '0);
        applyStimulus(1, 0, 0, '0, 1, 32'h00000013);
        compareWord("post_err_addr", imem_addr_o, 32'hBFC00000);

        // Randomized traffic against the model
        pct = 100;
        deadCount = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) begin
                case ((i / 500) % 3)
                    0: pct = 100;
                    1: pct = 60;
                    default: pct = 25;
                endcase
            end
            deadCount = mDead ? deadCount + 1 : 0;
            rst = !(($urandom_range(0, 299) == 0) || deadCount > 20);
            stall = ($urandom_range(0, 99) < 25);
            rv = ($urandom_range(0, 99) < 8);
            rnd = $urandom;
            case ($urandom_range(0, 19))
                0: rt = 32'hFFFFFFFC;
                1: rt = {rnd[31:2], 2'(($urandom_range(1, 3)))};
                default: rt = {rnd[31:2], 2'b00};
            endcase
            ready = rst && modelReq() && ($urandom_range(0, 99) < pct);
            applyStimulus(rst, stall, rv, rt, ready, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
